entity_pixel_renderer: RTL and testbench

Pipelined sprite-pixel stage directly downstream of the entity detector-combination unit. Each clock it takes the 9-bit per-pixel entity word (`{row[2:0], id[3:0], orient[1:0]}` or sentinel 9'h1FF), fetches the matching 8-pixel sprite row from an external synchronous sprite ROM, and applies orientation. It then emits a registered per-pixel "entity pixel on" bit plus entity ID for the palette/colour mixer, aligned to a delayed display-enable.

---
 rtl/entity_pixel_renderer.sv | 148 ++++++++++++++
 tb/tb_entity_pixel_renderer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/entity_pixel_renderer.sv
// ============================================================================
// Module  : entity_pixel_renderer
// Brief   : 3-stage sprite pixel pipeline: entity word -> sprite ROM row ->
//           oriented pixel bit + ID. Define ENTITY_ROTATE_EN for full rotation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module entity_pixel_renderer #(
    parameter int UPSCALE_FACTOR = 5,
    parameter int TILE_LEN_PIXEL = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       display_on,
    input  logic [8:0] entity_in,
    input  logic [9:0] counter_H,
    output logic [6:0] rom_addr,
    output logic       rom_en,
    input  logic [7:0] rom_data,
    output logic       pixel_on,
    output logic [3:0] pixel_id,
    output logic       pixel_valid
);

    localparam logic [8:0] C_NO_ENTITY = 9'h1FF;
    localparam logic [3:0] C_NO_ID     = 4'hF;

    logic [9:0] w_tile_off;
    logic [2:0] w_col;
    logic [2:0] w_ra;
    logic [2:0] w_cb;
    logic [6:0] w_addr;
    logic       w_pixel_on;

    logic       s1_vld_q;
    logic [2:0] s1_row_q;
    logic [3:0] s1_id_q;
    logic [1:0] s1_orient_q;
    logic [2:0] s1_col_q;
    logic       s1_disp_q;

    logic       last_vld_q;
    logic [6:0] last_addr_q;

    logic       s2_vld_q;
    logic [3:0] s2_id_q;
    logic [2:0] s2_cb_q;
    logic       s2_disp_q;

    logic       pixel_on_q;
    logic [3:0] pixel_id_q;
    logic       pixel_valid_q;

    assign w_tile_off = counter_H % 10'(TILE_LEN_PIXEL);
    assign w_col      = 3'(w_tile_off / 10'(UPSCALE_FACTOR));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_vld_q    <= 1'b0;
            s1_row_q    <= 3'd0;
            s1_id_q     <= 4'd0;
            s1_orient_q <= 2'd0;
            s1_col_q    <= 3'd0;
            s1_disp_q   <= 1'b0;
        end else begin
            s1_vld_q    <= (entity_in != C_NO_ENTITY);
            s1_row_q    <= entity_in[8:6];
            s1_id_q     <= entity_in[5:2];
            s1_orient_q <= entity_in[1:0];
            s1_col_q    <= w_col;
            s1_disp_q   <= display_on;
        end
    end

`ifdef ENTITY_ROTATE_EN
    // Clockwise rotation; 7-x is the bitwise complement for 3-bit coordinates.
    always_comb begin
        w_ra = s1_row_q;
        w_cb = s1_col_q;
        case (s1_orient_q)
            2'b00: begin w_ra = s1_row_q;  w_cb = s1_col_q;  end
            2'b01: begin w_ra = ~s1_col_q; w_cb = s1_row_q;  end
            2'b10: begin w_ra = ~s1_row_q; w_cb = ~s1_col_q; end
            default: begin w_ra = s1_col_q; w_cb = ~s1_row_q; end
        endcase
    end
`else
    logic w_unused_orient_hi;
    assign w_unused_orient_hi = s1_orient_q[1];

    always_comb begin
        w_ra = s1_row_q;
        w_cb = s1_orient_q[0] ? ~s1_col_q : s1_col_q;
    end
`endif

    assign w_addr   = {s1_id_q, w_ra};
    assign rom_addr = s1_vld_q ? w_addr : last_addr_q;
    // Only fetch when the row actually changes so held ROM data is reused.
    assign rom_en   = s1_vld_q && (!last_vld_q || (w_addr != last_addr_q));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_vld_q  <= 1'b0;
            last_addr_q <= 7'd0;
        end else if (rom_en) begin
            last_vld_q  <= 1'b1;
            last_addr_q <= w_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_vld_q  <= 1'b0;
            s2_id_q   <= 4'd0;
            s2_cb_q   <= 3'd0;
            s2_disp_q <= 1'b0;
        end else begin
            s2_vld_q  <= s1_vld_q;
            s2_id_q   <= s1_id_q;
            s2_cb_q   <= w_cb;
            s2_disp_q <= s1_disp_q;
        end
    end

    // Bit 7 of the ROM row is the leftmost sprite pixel.
    assign w_pixel_on = s2_vld_q && s2_disp_q && rom_data[~s2_cb_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_on_q    <= 1'b0;
            pixel_id_q    <= C_NO_ID;
            pixel_valid_q <= 1'b0;
        end else begin
            pixel_on_q    <= w_pixel_on;
            pixel_id_q    <= w_pixel_on ? s2_id_q : C_NO_ID;
            pixel_valid_q <= s2_disp_q;
        end
    end

    assign pixel_on    = pixel_on_q;
    assign pixel_id    = pixel_id_q;
    assign pixel_valid = pixel_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_entity_pixel_renderer.sv
// ============================================================================
// Module  : tb_entity_pixel_renderer
// Brief   : Scoreboard bench for entity_pixel_renderer with a 1-cycle ROM model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_entity_pixel_renderer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       display_on = 1'b0;
    logic [8:0] entity_in = 9'h1FF;
    logic [9:0] counter_H = 10'd0;
    logic [6:0] rom_addr;
    logic       rom_en;
    logic [7:0] rom_data = 8'd0;
    logic       pixel_on;
    logic [3:0] pixel_id;
    logic       pixel_valid;

    logic [7:0] rom [128];
    int         n_checks = 0;
    int         n_pass = 0;
    int         fetch_cnt = 0;

    typedef struct packed {
        logic       on;
        logic [3:0] id;
        logic       valid;
    } exp_t;

    exp_t       sb[$];
    logic       m_last_vld;
    logic [6:0] m_last_addr;
    logic       prev_en;
    logic [6:0] prev_addr;

    entity_pixel_renderer #(
        .UPSCALE_FACTOR(5),
        .TILE_LEN_PIXEL(40)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .display_on (display_on),
        .entity_in  (entity_in),
        .counter_H  (counter_H),
        .rom_addr   (rom_addr),
        .rom_en     (rom_en),
        .rom_data   (rom_data),
        .pixel_on   (pixel_on),
        .pixel_id   (pixel_id),
        .pixel_valid(pixel_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) begin
            rom_data  <= rom[rom_addr];
            fetch_cnt <= fetch_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [5:0] map_rc(input logic [2:0] r, input logic [2:0] c, input logic [1:0] o);
`ifdef ENTITY_ROTATE_EN
        case (o)
            2'b00:   return {r, c};
            2'b01:   return {3'(7 - c), r};
            2'b10:   return {3'(7 - r), 3'(7 - c)};
            default: return {c, 3'(7 - r)};
        endcase
`else
        return o[0] ? {r, 3'(7 - c)} : {r, c};
`endif
    endfunction

    // Called on a falling edge: check outputs, then drive the next pixel.
    task automatic step(input logic disp, input logic [8:0] ent, input logic [9:0] h);
        exp_t       e;
        exp_t       n;
        logic       vld;
        logic [2:0] c;
        logic [5:0] m;
        logic [6:0] a;
        logic       en;
        logic [7:0] row;
        e = sb.pop_front();
        check_eq("pixel_on", 32'(pixel_on), 32'(e.on));
        check_eq("pixel_id", 32'(pixel_id), 32'(e.id));
        check_eq("pixel_valid", 32'(pixel_valid), 32'(e.valid));
        check_eq("rom_en", 32'(rom_en), 32'(prev_en));
        check_eq("rom_addr", 32'(rom_addr), 32'(prev_addr));
        vld = (ent != 9'h1FF);
        c   = 3'((h % 10'd40) / 10'd5);
        m   = map_rc(ent[8:6], c, ent[1:0]);
        a   = vld ? {ent[5:2], m[5:3]} : m_last_addr;
        en  = vld && (!m_last_vld || (a != m_last_addr));
        if (en) begin
            m_last_vld  = 1'b1;
            m_last_addr = a;
        end
        row     = rom[a];
        n.on    = vld && disp && row[3'(7 - m[2:0])];
        n.id    = n.on ? ent[5:2] : 4'hF;
        n.valid = disp;
        sb.push_back(n);
        prev_en    = en;
        prev_addr  = a;
        display_on = disp;
        entity_in  = ent;
        counter_H  = h;
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        check_eq("rst_pixel_on", 32'(pixel_on), 32'd0);
        check_eq("rst_pixel_id", 32'(pixel_id), 32'hF);
        check_eq("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        check_eq("rst_rom_en", 32'(rom_en), 32'd0);
        check_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        repeat (3) sb.push_back('{on: 1'b0, id: 4'hF, valid: 1'b0});
        m_last_vld  = 1'b0;
        m_last_addr = 7'd0;
        prev_en     = 1'b0;
        prev_addr   = 7'd0;
    endtask

    task automatic sweep(input logic [8:0] ent, input int h0, input int h1,
                         input int exp_fetch, input string tag);
        int c0;
        step(1'b1, 9'h1FF, 10'd0);
        c0 = fetch_cnt;
        for (int h = h0; h <= h1; h++) step(1'b1, ent, 10'(h));
        step(1'b1, 9'h1FF, 10'd0);
        check_eq(tag, 32'(fetch_cnt - c0), 32'(exp_fetch));
    endtask

    initial begin
        int         c0;
        logic [9:0] h;
        logic [8:0] pool [6];
`ifdef ENTITY_ROTATE_EN
        localparam int ROT = 1;
`else
        localparam int ROT = 0;
`endif
        for (int i = 0; i < 128; i++) rom[i] = 8'($urandom);
        rom[7'h1A]        = 8'b1000_0001;
        rom[{4'd4, 3'd2}] = 8'b1100_0000;
        rom[{4'd5, 3'd1}] = 8'hA5;
        pool[0] = {3'd2, 4'd3, 2'b00};
        pool[1] = {3'd2, 4'd3, 2'b01};
        pool[2] = {3'd5, 4'd9, 2'b10};
        pool[3] = {3'd7, 4'hF, 2'b11};
        pool[4] = 9'h1FF;
        pool[5] = {3'd1, 4'd5, 2'b00};

        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 9'h0A4, 10'(i));
        do_reset();

        sweep({3'd2, 4'd3, 2'b00}, 80, 119, 1, "fetch_row_plain");
        sweep({3'd2, 4'd3, 2'b01}, 80, 119, (ROT != 0) ? 8 : 0, "fetch_row_orient1");
        sweep({3'd2, 4'd4, 2'b01}, 80, 119, (ROT != 0) ? 8 : 1, "fetch_row_c0");

        step(1'b1, 9'h1FF, 10'd0);
        c0 = fetch_cnt;
        for (int i = 0; i < 100; i++) step(i < 80, 9'h1FF, 10'(i));
        check_eq("fetch_sentinel_line", 32'(fetch_cnt - c0), 32'd0);

        sweep({3'd0, 4'd1, 2'b01}, 0, 39, (ROT != 0) ? 8 : 1, "fetch_rot_sweep");

        for (int i = 0; i < 40; i++) step(i >= 20, {3'd1, 4'd5, 2'b00}, 10'(i));
        for (int i = 0; i < 40; i++) step(i < 12 || i >= 27, {3'd1, 4'd5, 2'b01}, 10'(i));
        for (int i = 35; i <= 45; i++) step(1'b1, {3'd7, 4'hF, 2'b00}, 10'(i));

        h = 10'd0;
        for (int i = 0; i < 300; i++) begin
            h = (h == 10'd799) ? 10'd0 : h + 10'd1;
            step($urandom_range(0, 9) != 0, pool[$urandom_range(0, 5)], h);
            if (i == 150) begin
                entity_in = 9'h0A4;
                do_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
